// File: rtl/lnvd_adc_sequencer.sv
// Round-robin conversion scheduler for the LNVD ADC command/response stream.
// One frame per period tick; each enabled slot issues one command and captures its result.
module lnvd_adc_sequencer #(
    parameter int                    NUM_CH  = 4,
    parameter logic [NUM_CH*5-1:0]   CH_MAP  = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                    PERIOD  = 1000,
    parameter int                    TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     clr_err,
    output logic                     cmd_valid,
    output logic [4:0]               cmd_channel,
    output logic                     cmd_sop,
    output logic                     cmd_eop,
    input  logic                     cmd_ready,
    input  logic                     rsp_valid,
    input  logic [4:0]               rsp_channel,
    input  logic [11:0]              rsp_data,
    output logic [NUM_CH*12-1:0]     data_out,
    output logic [NUM_CH-1:0]        data_valid,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun_err
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [11:0]         data_q [NUM_CH];
    logic [11:0]         data_d [NUM_CH];
    logic [NUM_CH-1:0]   dv_q, dv_d;
    logic                frame_done_q, frame_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_err_q, overrun_err_d;
    logic                tick, rsp_hit, expired;
    logic [NUM_CH-1:0]   remaining;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) lowest_set = IDX_W'(i);
    endfunction

    function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_CH-1:0] m);
        highest_set = '0;
        for (int i = 0; i < NUM_CH; i++) if (m[i]) highest_set = IDX_W'(i);
    endfunction

    // Enabled slots strictly after idx; empty means idx is the last slot of the frame.
    function automatic logic [NUM_CH-1:0] slots_after(input logic [NUM_CH-1:0] m,
                                                      input logic [IDX_W-1:0] idx);
        slots_after = m;
        for (int i = 0; i < NUM_CH; i++) if (IDX_W'(i) <= idx) slots_after[i] = 1'b0;
    endfunction

    function automatic logic [4:0] map_ch(input logic [IDX_W-1:0] idx);
        map_ch = '0;
        for (int i = 0; i < NUM_CH; i++) if (IDX_W'(i) == idx) map_ch = CH_MAP[5*i +: 5];
    endfunction

    always_comb begin
        tick      = enable && (per_cnt_q == PER_W'(PERIOD - 1));
        per_cnt_d = (!enable || tick) ? '0 : per_cnt_q + PER_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mask_d        = mask_q;
        to_cnt_d      = to_cnt_q;
        data_d        = data_q;
        dv_d          = dv_q;
        frame_done_d  = 1'b0;
        timeout_err_d = clr_err ? 1'b0 : timeout_err_q;
        overrun_err_d = clr_err ? 1'b0 : overrun_err_q;
        rsp_hit       = 1'b0;
        expired       = 1'b0;
        remaining     = '0;

        if (tick && state_q != S_IDLE) overrun_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tick && |ch_mask) begin
                    mask_d  = ch_mask;
                    idx_d   = lowest_set(ch_mask);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                rsp_hit = rsp_valid && (rsp_channel == map_ch(idx_q));
                expired = !rsp_hit && (to_cnt_q == TO_W'(TIMEOUT - 1));
                if (rsp_hit) begin
                    data_d[idx_q] = rsp_data;
                    dv_d[idx_q]   = 1'b1;
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                // A timed-out slot advances exactly like a captured one.
                if (rsp_hit || expired) begin
                    remaining = slots_after(mask_q, idx_q);
                    if (|remaining) begin
                        idx_d   = lowest_set(remaining);
                        state_d = S_ISSUE;
                    end else begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            mask_q        <= '0;
            per_cnt_q     <= '0;
            to_cnt_q      <= '0;
            dv_q          <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            per_cnt_q     <= per_cnt_d;
            to_cnt_q      <= to_cnt_d;
            dv_q          <= dv_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            data_q        <= data_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign cmd_valid   = (state_q == S_ISSUE);
    assign cmd_channel = cmd_valid ? map_ch(idx_q) : 5'd0;
    assign cmd_sop     = cmd_valid && (idx_q == lowest_set(mask_q));
    assign cmd_eop     = cmd_valid && (idx_q == highest_set(mask_q));
    assign data_valid  = dv_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
        assign data_out[12*gi +: 12] = data_q[gi];
    end
endmodule

// File: tb/tb_lnvd_adc_sequencer.sv
// Directed bench for lnvd_adc_sequencer: ADC responder model, command scoreboard, data model.
module tb_lnvd_adc_sequencer;
    localparam int NUM_CH  = 4;
    localparam int PERIOD  = 64;
    localparam int TIMEOUT = 20;

    logic                clk = 1'b0;
    logic                rst_n, enable, clr_err;
    logic [NUM_CH-1:0]   ch_mask, data_valid;
    logic                cmd_valid, cmd_sop, cmd_eop, cmd_ready, rsp_valid;
    logic [4:0]          cmd_channel, rsp_channel;
    logic [11:0]         rsp_data;
    logic [NUM_CH*12-1:0] data_out;
    logic                frame_done, busy, timeout_err, overrun_err;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          acc_cnt = 0, last_acc_cyc = 0, fd_cnt = 0, exp_frames = 0;
    logic [6:0]  sb_q[$];
    int          sop_cyc[$];
    logic        hold_ready = 1'b0, sop_prev = 1'b0;
    logic [4:0]  drop_ch = 5'd0;
    logic [11:0] rsp_base = 12'h0;
    logic [11:0] exp_data [NUM_CH];
    logic [NUM_CH-1:0] exp_dv;

    lnvd_adc_sequencer #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .clr_err(clr_err),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
        .rsp_data(rsp_data), .data_out(data_out), .data_valid(data_valid),
        .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [NUM_CH*12-1:0] exp_packed();
        for (int i = 0; i < NUM_CH; i++) exp_packed[12*i +: 12] = exp_data[i];
    endfunction

    task automatic reset_exp();
        sb_q.delete();
        for (int i = 0; i < NUM_CH; i++) exp_data[i] = 12'h0;
        exp_dv = '0;
    endtask

    // Expected commands go to the scoreboard; slot i targets ADC channel i+1.
    task automatic push_frame(input logic [NUM_CH-1:0] m);
        int first = -1;
        int last  = -1;
        for (int i = 0; i < NUM_CH; i++) if (m[i]) begin
            if (first < 0) first = i;
            last = i;
        end
        for (int i = 0; i < NUM_CH; i++) if (m[i]) begin
            logic [4:0] ch;
            ch = 5'(i + 1);
            sb_q.push_back({ch, (i == first), (i == last)});
            if (ch != drop_ch) begin
                exp_data[i] = rsp_base + 12'(ch);
                exp_dv[i]   = 1'b1;
            end
        end
        exp_frames++;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin step(); n++; end while (!frame_done && n < 300);
        check(tag, frame_done, 1'b1);
    endtask

    // ADC model: ready two cycles after valid, response about five cycles after accept.
    initial begin
        logic [4:0] acc_ch;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_channel = 5'd0; rsp_data = 12'h0;
        forever begin
            @(negedge clk);
            if (cmd_valid && !hold_ready) begin
                @(negedge clk);
                cmd_ready = 1'b1;
                acc_ch    = cmd_channel;
                @(negedge clk);
                cmd_ready = 1'b0;
                repeat (4) @(negedge clk);
                if (acc_ch != drop_ch) begin
                    rsp_valid = 1'b1; rsp_channel = acc_ch; rsp_data = rsp_base + 12'(acc_ch);
                    @(negedge clk);
                    rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pop and compare each accepted command, count frames, log frame starts.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && cmd_valid && cmd_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc + 1;
                if (sb_q.size() == 0) check("cmd_unexpected", {cmd_channel, cmd_sop, cmd_eop}, 64'h0);
                else begin
                    e = sb_q.pop_front();
                    check("cmd_ch_sop_eop", {cmd_channel, cmd_sop, cmd_eop}, e);
                    $display("[TB] cyc %0d cmd ch=%0d sop=%0b eop=%0b", cyc, cmd_channel, cmd_sop, cmd_eop);
                end
            end
            if (frame_done) fd_cnt++;
            if (cmd_valid && cmd_sop && !sop_prev) sop_cyc.push_back(cyc);
            sop_prev = cmd_valid && cmd_sop;
        end
    end

    initial begin
        logic       seen, stable;
        logic [7:0] snap;
        int         en_cyc, n, a0;
        rst_n = 1'b0; enable = 1'b0; ch_mask = '0; clr_err = 1'b0;
        reset_exp();

        for (int k = 0; k < 4; k++) begin
            step();
            enable = 1'($urandom); ch_mask = NUM_CH'($urandom); clr_err = 1'($urandom);
            check("reset_outputs", {cmd_valid, cmd_channel, cmd_sop, cmd_eop, data_out, data_valid,
                                    frame_done, busy, timeout_err, overrun_err}, 64'h0);
        end
        enable = 1'b0; clr_err = 1'b0; ch_mask = '0;
        step();
        rst_n = 1'b1;

        // Ticks with an empty mask must not start a frame.
        enable = 1'b1; seen = 1'b0;
        repeat (80) begin step(); if (cmd_valid || busy || frame_done) seen = 1'b1; end
        check("no_frame_mask0", seen, 1'b0);
        enable = 1'b0;
        step();

        // Full mask, two consecutive frames.
        rsp_base = 12'h100; ch_mask = 4'hF;
        push_frame(4'hF); push_frame(4'hF);
        sop_cyc.delete();
        enable = 1'b1; en_cyc = cyc;
        wait_frame("frame1_done");
        check("frame1_data", data_out, exp_packed());
        check("frame1_valid", data_valid, exp_dv);
        wait_frame("frame2_done");
        enable = 1'b0;
        check("frame_start_count", sop_cyc.size(), 2);
        if (sop_cyc.size() >= 2) begin
            check("first_tick_latency", sop_cyc[0] - en_cyc, PERIOD);
            check("frame_spacing", sop_cyc[1] - sop_cyc[0], PERIOD);
        end

        // ch3 response dropped: timeout, slot 2 keeps 0x103, frame still completes.
        rsp_base = 12'h200; drop_ch = 5'd3;
        push_frame(4'hF);
        enable = 1'b1; n = 0;
        do begin step(); n++; end while (!timeout_err && n < 400);
        check("timeout_seen", timeout_err, 1'b1);
        check("timeout_latency", cyc - last_acc_cyc, TIMEOUT);
        wait_frame("timeout_frame_done");
        enable = 1'b0; drop_ch = 5'd0;
        check("timeout_data", data_out, exp_packed());
        check("timeout_sticky", timeout_err, 1'b1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("timeout_clr", timeout_err, 1'b0);

        // cmd_ready held low across a tick: command stable, overrun flagged.
        rsp_base = 12'h400; hold_ready = 1'b1;
        push_frame(4'hF);
        enable = 1'b1; n = 0;
        do begin step(); n++; end while (!cmd_valid && n < 200);
        check("hold_cmd_valid", cmd_valid, 1'b1);
        snap = {cmd_valid, cmd_channel, cmd_sop, cmd_eop}; stable = 1'b1;
        repeat (70) begin
            step();
            if ({cmd_valid, cmd_channel, cmd_sop, cmd_eop} !== snap) stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        check("overrun_set", overrun_err, 1'b1);
        check("busy_hold", busy, 1'b1);
        hold_ready = 1'b0;
        wait_frame("hold_frame_done");
        enable = 1'b0;
        check("hold_data", data_out, exp_packed());
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("overrun_clr", overrun_err, 1'b0);

        // Reset while waiting for a response; the late response must be ignored.
        rsp_base = 12'h500;
        push_frame(4'hF);
        enable = 1'b1; a0 = acc_cnt; n = 0;
        do begin step(); n++; end while (acc_cnt == a0 && n < 200);
        step();
        check("pre_reset_wait", {busy, cmd_valid}, 2'b10);
        enable = 1'b0; rst_n = 1'b0;
        #1;
        check("async_reset", {cmd_valid, cmd_channel, cmd_sop, cmd_eop, data_out, data_valid,
                              frame_done, busy, timeout_err, overrun_err}, 64'h0);
        reset_exp(); exp_frames--;
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("late_rsp_ignored", {data_valid, data_out, busy}, 64'h0);
        rsp_base = 12'h600;
        push_frame(4'hF);
        enable = 1'b1;
        wait_frame("restart_frame_done");
        enable = 1'b0;
        check("restart_data", data_out, exp_packed());

        // Fresh reset, sparse mask: only ch2 (sop) and ch4 (eop).
        rst_n = 1'b0; step(); rst_n = 1'b1;
        reset_exp();
        rsp_base = 12'h300; ch_mask = 4'b1010;
        push_frame(4'b1010);
        enable = 1'b1;
        wait_frame("sparse_frame_done");
        enable = 1'b0;
        check("sparse_data", data_out, exp_packed());
        check("sparse_valid", data_valid, 4'b1010);

        repeat (5) step();
        check("sb_drained", sb_q.size(), 0);
        check("frame_count", fd_cnt, exp_frames);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
